// File: rtl/sample_ring_writer.sv
// Packs two 16-bit samples per 32-bit word and writes them round a ring through an Avalon-MM master.
// Optional feature macro: RING_OVERRUN_CNT_EN (counts samples offered while a write is in flight).
module sample_ring_writer #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH_WORDS = 1024,
  parameter int FRAME_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [15:0]           snk_data,
  input  logic                  snk_valid,
  output logic                  snk_ready,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic [3:0]            avm_byteenable,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic [31:0]           avm_writedata,
  input  logic                  avm_waitrequest,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic                  frame_done,
  output logic                  busy,
  output logic [15:0]           overrun_count
);

  localparam int FCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST   = ADDR_WIDTH'(DEPTH_WORDS - 1);
  localparam logic [FCW-1:0]        FRAME_LAST = FCW'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_HALF,
    S_WRITE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     lo_q;
  logic [FCW-1:0]  frame_cnt;
  logic            accept;
  logic            complete;

  assign accept   = snk_valid & snk_ready;
  assign complete = (state_q == S_WRITE) & ~avm_waitrequest;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (accept)                state_d = S_HALF;
      S_HALF:  if (accept || flush)       state_d = S_WRITE;
      S_WRITE: if (!avm_waitrequest)      state_d = S_EMPTY;
      default:                            state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    snk_ready = enable & (state_q != S_WRITE);
    busy      = (state_q != S_EMPTY);
  end

  // Bus outputs are loaded on entry to WRITE and then held untouched until completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      lo_q           <= '0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      wr_ptr         <= '0;
      frame_cnt      <= '0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state_q == S_EMPTY && accept) lo_q <= snk_data;

      if (state_q == S_HALF && (accept || flush)) begin
        avm_address    <= wr_ptr;
        avm_chipselect <= 1'b1;
        avm_write      <= 1'b1;
        if (accept) begin
          avm_writedata  <= {snk_data, lo_q};
          avm_byteenable <= 4'b1111;
        end else begin
          avm_writedata  <= {16'h0000, lo_q};
          avm_byteenable <= 4'b0011;
        end
      end

      if (complete) begin
        avm_write      <= 1'b0;
        avm_chipselect <= 1'b0;
        wr_ptr         <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + ADDR_WIDTH'(1);
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          frame_cnt <= frame_cnt + FCW'(1);
        end
      end
    end
  end

`ifdef RING_OVERRUN_CNT_EN
  logic [15:0] overrun_q;

  always_ff @(posedge clk) begin
    if (reset)
      overrun_q <= '0;
    else if (enable && snk_valid && !snk_ready && overrun_q != 16'hFFFF)
      overrun_q <= overrun_q + 16'd1;
  end

  assign overrun_count = overrun_q;
`else
  assign overrun_count = 16'h0000;
`endif

endmodule

// File: tb/tb_sample_ring_writer.sv
// Self-checking bench for sample_ring_writer: a word-level ring model checked every cycle plus literal pins.
module tb_sample_ring_writer;

  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int FRAME = 256;

  logic          clk, reset, enable, flush, snk_valid, snk_ready;
  logic [15:0]   snk_data;
  logic [AW-1:0] avm_address, wr_ptr;
  logic [3:0]    avm_byteenable;
  logic          avm_chipselect, avm_write, avm_waitrequest;
  logic [31:0]   avm_writedata;
  logic          frame_done, busy;
  logic [15:0]   overrun_count;

  sample_ring_writer #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH), .FRAME_WORDS(FRAME)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .wr_ptr(wr_ptr), .frame_done(frame_done), .busy(busy),
    .overrun_count(overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level model: expected words in flight, held half, ring pointer, word count.
  typedef struct { logic [31:0] data; logic [3:0] be; } wr_t;
  wr_t         m_q[$];
  logic        m_pend = 1'b0;
  logic [15:0] m_lo   = '0;
  int          m_ptr  = 0;
  int          m_words = 0;
  logic        m_fd   = 1'b0;
  int          m_ovr  = 0;

  int          wr_done = 0, aw_cnt = 0, fd_cnt = 0;
  logic [31:0] last_data, last_addr, last_be, fd_last_ptr;

  always @(negedge clk) begin
    int qn;
    qn = m_q.size();
    check("wr_ptr", 32'(wr_ptr), 32'(m_ptr));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("busy", 32'(busy), 32'(m_pend || qn > 0));
    check("snk_ready", 32'(snk_ready), 32'(enable && qn == 0));
    check("avm_write", 32'(avm_write), 32'(qn > 0));
`ifdef RING_OVERRUN_CNT_EN
    check("overrun_count", 32'(overrun_count), 32'(m_ovr));
`else
    check("overrun_count", 32'(overrun_count), 32'h0);
`endif
    if (qn > 0) begin
      check("avm_address", 32'(avm_address), 32'(m_ptr));
      check("avm_writedata", avm_writedata, m_q[0].data);
      check("avm_byteenable", 32'(avm_byteenable), 32'(m_q[0].be));
      check("avm_chipselect", 32'(avm_chipselect), 32'h1);
    end

    if (avm_write) aw_cnt++;
    if (avm_write && !avm_waitrequest) begin
      wr_done++;
      last_data = avm_writedata;
      last_addr = 32'(avm_address);
      last_be   = 32'(avm_byteenable);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_last_ptr = 32'(wr_ptr);
    end

    // Advance the model to what the coming edge must produce.
    if (reset) begin
      m_q.delete();
      m_pend = 1'b0; m_lo = '0; m_ptr = 0; m_words = 0; m_fd = 1'b0; m_ovr = 0;
    end else begin
      m_fd = 1'b0;
      if (qn > 0) begin
        if (enable && snk_valid && m_ovr < 65535) m_ovr++;
        if (!avm_waitrequest) begin
          void'(m_q.pop_front());
          m_ptr = (m_ptr + 1) % DEPTH;
          m_words++;
          m_fd = (m_words % FRAME == 0);
        end
      end else if (enable && snk_valid) begin
        if (m_pend) begin
          m_q.push_back('{data: {snk_data, m_lo}, be: 4'hF});
          m_pend = 1'b0;
        end else begin
          m_lo = snk_data;
          m_pend = 1'b1;
        end
      end else if (flush && m_pend) begin
        m_q.push_back('{data: {16'h0000, m_lo}, be: 4'h3});
        m_pend = 1'b0;
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d);
    snk_data  = d;
    snk_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (snk_ready) begin
        @(posedge clk);
        #1;
        snk_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 32'h1, 32'h0);
    snk_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy) begin
        cyc();
        return;
      end
    end
    check("idle_timeout", 32'h1, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    int base;
    reset = 1'b1; enable = 1'b0; flush = 1'b0; snk_valid = 1'b0;
    snk_data = '0; avm_waitrequest = 1'b0;
    cyc(3);
    check("rst_avm_write", 32'(avm_write), 32'h0);
    check("rst_wr_ptr", 32'(wr_ptr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    enable = 1'b1;

    // Back-to-back pair
    send(16'h1111);
    send(16'h2222);
    wait_idle();
    check("t1_wr_done", 32'(wr_done), 32'd1);
    check("t1_addr", last_addr, 32'h0);
    check("t1_data", last_data, 32'h2222_1111);
    check("t1_be", last_be, 32'hF);
    check("t1_wr_ptr", 32'(wr_ptr), 32'd1);

    // Flushed half word
    send(16'hABCD);
    cyc(2);
    pulse_flush();
    wait_idle();
    check("t2_data", last_data, 32'h0000_ABCD);
    check("t2_be", last_be, 32'h3);
    check("t2_wr_ptr", 32'(wr_ptr), 32'd2);
    check("t2_busy", 32'(busy), 32'h0);

    // Flush with nothing held
    base = wr_done;
    pulse_flush();
    cyc(3);
    check("idle_flush_writes", 32'(wr_done), 32'(base));

    // enable dropped while holding a half
    send(16'h5555);
    enable = 1'b0;
    snk_valid = 1'b1; snk_data = 16'h6666;
    cyc(3);
    check("en_low_ready", 32'(snk_ready), 32'h0);
    snk_valid = 1'b0;
    enable = 1'b1;
    pulse_flush();
    wait_idle();
    check("en_low_data", last_data, 32'h0000_5555);
    check("en_low_wr_ptr", 32'(wr_ptr), 32'd3);

    // Stalled write with a sample pending
    aw_cnt = 0;
    base = wr_done;
    avm_waitrequest = 1'b1;
    send(16'h0101);
    send(16'h0202);
    snk_valid = 1'b1; snk_data = 16'h7777;
    cyc(4);
    avm_waitrequest = 1'b0;
    cyc();
    snk_valid = 1'b0;
    wait_idle();
    check("t3_write_cycles", 32'(aw_cnt), 32'd5);
    check("t3_writes", 32'(wr_done), 32'(base + 1));
    check("t3_data", last_data, 32'h0202_0101);
    check("t3_wr_ptr", 32'(wr_ptr), 32'd4);
`ifdef RING_OVERRUN_CNT_EN
    check("t3_overrun", 32'(overrun_count), 32'd5);
`else
    check("t3_overrun", 32'(overrun_count), 32'd0);
`endif

    // Flush coinciding with the second sample
    base = wr_done;
    send(16'h1234);
    snk_valid = 1'b1; snk_data = 16'h8888; flush = 1'b1;
    cyc();
    snk_valid = 1'b0; flush = 1'b0;
    wait_idle();
    cyc(2);
    check("t6_writes", 32'(wr_done), 32'(base + 1));
    check("t6_be", last_be, 32'hF);
    check("t6_data", last_data, 32'h8888_1234);

    // Reset while a write is stalled
    avm_waitrequest = 1'b1;
    send(16'hDEAD);
    send(16'hBEEF);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    check("t5_avm_write", 32'(avm_write), 32'h0);
    check("t5_wr_ptr", 32'(wr_ptr), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    send(16'h0A0A);
    send(16'h0B0B);
    wait_idle();
    check("t5_addr", last_addr, 32'h0);
    check("t5_data", last_data, 32'h0B0B_0A0A);

    // Full ring: 2048 samples, 1024 words
    do_reset();
    base = wr_done;
    fd_cnt = 0;
    for (int i = 0; i < 2048; i++) send(16'(i * 37 + 5));
    wait_idle();
    cyc(2);
    check("t4_writes", 32'(wr_done), 32'(base + 1024));
    check("t4_frames", 32'(fd_cnt), 32'd4);
    check("t4_last_frame_ptr", fd_last_ptr, 32'h0);
    check("t4_wr_ptr", 32'(wr_ptr), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
